// File: rtl/char_stream_framer.sv
// char_stream_framer
// Upstream feeder for the vowel/consonant password checker. Raw ASCII bytes
// arrive over a valid/ready handshake and are buffered in a small FIFO. One
// byte is popped per cycle unless hold is high. Each popped byte is classified:
// letters are folded to lowercase and emitted, separators close the current
// word with a one-cycle strobe, and anything else is counted and discarded.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   in_valid     upstream byte valid
//   in_data      upstream ASCII byte
//   in_ready     FIFO can accept a byte (not full)
//   hold         freezes the FIFO read side, the word FSM and the word length
//   out_en       out_char is valid this cycle
//   out_char     lowercase letter 'a'..'z'
//   out_eow      one-cycle end-of-word strobe
//   out_too_long qualifies out_eow; the word held more than MAX_LEN letters
//   drop_cnt     saturating count of discarded non-letter, non-separator bytes
//   fifo_count   current FIFO occupancy
module char_stream_framer #(
    parameter int DEPTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     hold,
    output logic                     out_en,
    output logic [7:0]               out_char,
    output logic                     out_eow,
    output logic                     out_too_long,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_ZERO  = LW'(0);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IN_WORD = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

    // Byte classification helpers.
    function automatic logic is_upper(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    function automatic logic is_sep(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h0A) || (b == 8'h0D) || (b == 8'h00);
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] b);
        return is_upper(b) ? (b + 8'h20) : b;
    endfunction

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    state_t        state_r;
    logic [LW-1:0] len_r;

    logic          push_s;
    logic          pop_s;
    logic [7:0]    pop_byte_s;
    logic          pop_letter_s;
    logic          pop_sep_s;
    logic [7:0]    pop_lower_s;

    assign in_ready   = (count_r != CNT_FULL);
    assign fifo_count = count_r;

    // Handshake decode and classification of the byte at the FIFO head.
    always_comb begin
        push_s       = in_valid && in_ready;
        pop_s        = (count_r != CNT_EMPTY) && !hold;
        pop_byte_s   = mem_r[rd_ptr_r];
        pop_letter_s = is_upper(pop_byte_s) || is_lower(pop_byte_s);
        pop_sep_s    = is_sep(pop_byte_s);
        pop_lower_s  = to_lower(pop_byte_s);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_EMPTY;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Word FSM with registered checker-facing outputs; strobes default low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            len_r        <= LEN_ZERO;
            out_en       <= 1'b0;
            out_char     <= 8'h00;
            out_eow      <= 1'b0;
            out_too_long <= 1'b0;
            drop_cnt     <= 8'h00;
        end else begin
            out_en       <= 1'b0;
            out_eow      <= 1'b0;
            out_too_long <= 1'b0;
            if (pop_s) begin
                if (pop_letter_s) begin
                    case (state_r)
                        ST_IDLE: begin
                            out_en   <= 1'b1;
                            out_char <= pop_lower_s;
                            len_r    <= LEN_ONE;
                            state_r  <= ST_IN_WORD;
                        end
                        ST_IN_WORD: begin
                            if (len_r < LEN_MAX) begin
                                out_en   <= 1'b1;
                                out_char <= pop_lower_s;
                                len_r    <= len_r + LEN_ONE;
                            end else begin
                                // Word overflowed: swallow the rest until a separator.
                                state_r <= ST_SKIP;
                            end
                        end
                        ST_SKIP: begin
                            state_r <= ST_SKIP;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            len_r   <= LEN_ZERO;
                        end
                    endcase
                end else if (pop_sep_s) begin
                    case (state_r)
                        ST_IDLE: begin
                            // Empty words produce no strobe.
                            state_r <= ST_IDLE;
                        end
                        ST_IN_WORD: begin
                            out_eow      <= 1'b1;
                            out_too_long <= 1'b0;
                            len_r        <= LEN_ZERO;
                            state_r      <= ST_IDLE;
                        end
                        ST_SKIP: begin
                            out_eow      <= 1'b1;
                            out_too_long <= 1'b1;
                            len_r        <= LEN_ZERO;
                            state_r      <= ST_IDLE;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            len_r   <= LEN_ZERO;
                        end
                    endcase
                end else begin
                    // Non-letter, non-separator: counted, word state untouched.
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'h01;
                    end else begin
                        drop_cnt <= drop_cnt;
                    end
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_char_stream_framer.sv
module tb_char_stream_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       hold;

    logic       rdy16, en16, eow16, tl16;
    logic [7:0] ch16, drop16;
    logic [3:0] cnt16;
    logic       rdy4, en4, eow4, tl4;
    logic [7:0] ch4, drop4;
    logic [3:0] cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model state: letters seen in the current word (unbounded).
    int m_len16 = 0;
    int m_len4  = 0;
    int m_drop  = 0;
    int exp16[$];
    int exp4[$];
    int obs16[$];
    int obs4[$];

    char_stream_framer #(.DEPTH(8), .MAX_LEN(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy16), .hold(hold), .out_en(en16), .out_char(ch16),
        .out_eow(eow16), .out_too_long(tl16), .drop_cnt(drop16), .fifo_count(cnt16)
    );

    char_stream_framer #(.DEPTH(8), .MAX_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy4), .hold(hold), .out_en(en4), .out_char(ch4),
        .out_eow(eow4), .out_too_long(tl4), .drop_cnt(drop4), .fifo_count(cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output event capture: letters as their code, end-of-word as 256+too_long.
    always @(negedge clk) begin
        if (!reset) begin
            if (en16)  obs16.push_back(int'(ch16));
            if (eow16) obs16.push_back(256 + int'(tl16));
            if (en4)   obs4.push_back(int'(ch4));
            if (eow4)  obs4.push_back(256 + int'(tl4));
            if (en16 || eow16) check("excl16", {31'd0, en16 & eow16}, 32'd0);
            if (en4 || eow4)   check("excl4", {31'd0, en4 & eow4}, 32'd0);
        end
    end

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic is_separator(input logic [7:0] b);
        return b == 8'h20 || b == 8'h0A || b == 8'h0D || b == 8'h00;
    endfunction

    // Word-level model: first MAX_LEN letters of a word are emitted, a
    // separator closes a non-empty word, too_long iff it held > MAX_LEN letters.
    task automatic model_byte(input logic [7:0] b);
        int lc;
        if (is_letter(b)) begin
            lc = (b < 8'h61) ? int'(b) + 32 : int'(b);
            if (m_len16 < 16) exp16.push_back(lc);
            if (m_len4 < 4)   exp4.push_back(lc);
            m_len16++;
            m_len4++;
        end else if (is_separator(b)) begin
            if (m_len16 > 0) exp16.push_back(256 + ((m_len16 > 16) ? 1 : 0));
            if (m_len4 > 0)  exp4.push_back(256 + ((m_len4 > 4) ? 1 : 0));
            m_len16 = 0;
            m_len4  = 0;
        end else begin
            if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic push(input logic [7:0] b);
        int g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy16 && g < 100) begin
            hold = 1'b0;
            @(posedge clk); #1;
            g++;
        end
        if (!rdy16) begin
            check("push_timeout", {31'd0, rdy16}, 32'd1);
        end else begin
            @(posedge clk); #1;
            model_byte(b);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i]);
    endtask

    task automatic drain();
        int g = 0;
        hold = 1'b0;
        while (cnt16 != 4'd0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_cnt16", {28'd0, cnt16}, 32'd0);
        check("drain_cnt4", {28'd0, cnt4}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_len16"}, obs16.size(), exp16.size());
        n = (obs16.size() < exp16.size()) ? obs16.size() : exp16.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_s16_%0d", tag, i), obs16[i], exp16[i]);
        check({tag, "_len4"}, obs4.size(), exp4.size());
        n = (obs4.size() < exp4.size()) ? obs4.size() : exp4.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_s4_%0d", tag, i), obs4[i], exp4[i]);
        check({tag, "_drop16"}, {24'd0, drop16}, m_drop);
        check({tag, "_drop4"}, {24'd0, drop4}, m_drop);
        obs16.delete(); exp16.delete();
        obs4.delete();  exp4.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"}, {31'd0, rdy16}, 32'd1);
        check({tag, "_en"}, {31'd0, en16}, 32'd0);
        check({tag, "_char"}, {24'd0, ch16}, 32'd0);
        check({tag, "_eow"}, {31'd0, eow16}, 32'd0);
        check({tag, "_tl"}, {31'd0, tl16}, 32'd0);
        check({tag, "_drop"}, {24'd0, drop16}, 32'd0);
        check({tag, "_cnt"}, {28'd0, cnt16}, 32'd0);
        check({tag, "_cnt4"}, {28'd0, cnt4}, 32'd0);
    endtask

    initial begin
        int acc;
        logic rdy;
        logic [7:0] b;
        int r;
        string seps;
        string hold_bytes;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; hold = 1'b0;
        seps = " \n\r";
        hold_bytes = "abcdefghij";
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // Latency: accepted on edge k, visible after edge k+1.
        in_valid = 1'b1; in_data = 8'h61;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_byte(8'h61);
        check("lat_cnt1", {28'd0, cnt16}, 32'd1);
        check("lat_en0", {31'd0, en16}, 32'd0);
        @(posedge clk); #1;
        check("lat_en1", {31'd0, en16}, 32'd1);
        check("lat_char", {24'd0, ch16}, 32'h61);
        check("lat_cnt0", {28'd0, cnt16}, 32'd0);
        push_str("bc d");
        drain();
        compare("abc_d");

        push_str("\nAnDrE\n");
        drain();
        compare("andre");

        push_str("abcdefg ");
        drain();
        compare("maxlen");

        // Hold: only DEPTH bytes are accepted while the read side is frozen.
        hold = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = hold_bytes[i];
            rdy = rdy16;
            @(posedge clk); #1;
            if (rdy) begin
                model_byte(hold_bytes[i]);
                acc++;
            end
        end
        in_valid = 1'b0;
        check("hold_acc", acc, 32'd8);
        check("hold_cnt", {28'd0, cnt16}, 32'd8);
        check("hold_rdy", {31'd0, rdy16}, 32'd0);
        hold = 1'b0;
        @(posedge clk); #1;
        check("hold_cnt7", {28'd0, cnt16}, 32'd7);
        check("hold_rdy1", {31'd0, rdy16}, 32'd1);
        drain();
        compare("hold");

        push_str("\na1#b  c");
        drain();
        compare("drops");

        // Saturation of the drop counter.
        for (int i = 0; i < 260; i++) push(8'h23);
        drain();
        check("sat16", {24'd0, drop16}, 32'd255);
        compare("sat");

        // Randomized mixed traffic with random gaps and holds.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      b = 8'(8'h61 + $urandom_range(0, 25));
            else if (r < 6) b = 8'(8'h41 + $urandom_range(0, 25));
            else if (r < 7) b = seps[$urandom_range(0, 2)];
            else if (r < 8) b = 8'h00;
            else            b = 8'($urandom_range(0, 255));
            hold = ($urandom_range(0, 3) == 0);
            push(b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        push_str("\n");
        drain();
        compare("rand");

        // Reset mid-word: 'a' emitted, 'b' still buffered.
        push(8'h61);
        push(8'h62);
        check("pre_rst_en", {31'd0, en16}, 32'd1);
        check("pre_rst_char", {24'd0, ch16}, 32'h61);
        check("pre_rst_cnt", {28'd0, cnt16}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        obs16.delete(); exp16.delete();
        obs4.delete();  exp4.delete();
        m_len16 = 0; m_len4 = 0; m_drop = 0;
        push_str(" x");
        drain();
        check("post_rst_en", {31'd0, en16}, 32'd0);
        compare("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_stream_framer.md
Name: char_stream_framer

Overview:
- Upstream feeder for the vowel/consonant password checker.
- Accepts raw ASCII bytes over a valid/ready handshake and buffers them in a small FIFO.
- Folds uppercase to lowercase, drops non-letters, splits the stream into words at separators.
- Drives the checker's per-cycle enable/character inputs plus a one-cycle end-of-word strobe.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
MAX_LEN, 16, maximum letters per word passed downstream (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  upstream byte valid
in_data  input  8  upstream ASCII byte
in_ready  output  1  FIFO can accept (= not full)
hold  input  1  freezes the FIFO read side when high
out_en  output  1  out_char valid this cycle (checker en)
out_char  output  8  lowercase letter 'a'..'z' (checker data_in)
out_eow  output  1  one-cycle end-of-word strobe (checker check)
out_too_long  output  1  valid with out_eow; word exceeded MAX_LEN
drop_cnt  output  8  saturating count of discarded non-letter, non-separator bytes
fifo_count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: in_ready=1, out_en=0, out_char=0, out_eow=0, out_too_long=0, drop_cnt=0, fifo_count=0. FSM is in IDLE, word length is 0, FIFO pointers are 0.
- Push: a byte is written on any edge with in_valid && in_ready. in_ready = (fifo_count != DEPTH), combinational from registered count.
- Pop: one entry is popped per edge when FIFO is non-empty and hold=0.
- All outputs are registered and updated on the pop edge.
- On an edge with no pop, out_en, out_eow and out_too_long are driven 0.
- out_char holds its last value when no pop occurs.
- Latency: a byte accepted on edge k into an empty FIFO is popped on edge k+1 at the earliest. Its output is visible between edges k+1 and k+2.
- Simultaneous push and pop: both occur; fifo_count is unchanged. Pointers wrap modulo DEPTH.
- Classification of each popped byte b:
  - Letter: 0x41..0x5A is emitted as b+0x20; 0x61..0x7A is emitted as is.
  - Separator: 0x20, 0x0A, 0x0D, 0x00.
  - Other: dropped; drop_cnt increments, saturating at 255. No output; FSM and word length unchanged.
- FSM states: IDLE, IN_WORD, SKIP. len is the letter count of the current word.
- IDLE:
  - Letter -> out_en=1, out_char=lowercase, len=1, go to IN_WORD. If MAX_LEN==1, stay IN_WORD with len=1.
  - Separator -> no output, stay IDLE (empty words produce no strobe).
- IN_WORD:
  - Letter with len<MAX_LEN -> out_en=1, len+1.
  - Letter with len==MAX_LEN -> no out_en, go to SKIP.
  - Separator -> out_eow=1, out_too_long=0, len=0, go to IDLE.
- SKIP:
  - Letter -> dropped silently; drop_cnt not incremented.
  - Separator -> out_eow=1, out_too_long=1, len=0, go to IDLE.
- out_en and out_eow are never high in the same cycle.
- hold=1 freezes pop, FSM and len. Pushes continue until the FIFO is full.
- Reset asserted mid-word or mid-burst immediately clears FIFO contents, FSM, counters and outputs. No eow is emitted for the truncated word.

Test Plan:
- Push "abc d" back-to-back with hold=0 -> out_en sequence a,b,c on 3 consecutive cycles, then out_eow=1 (too_long=0). Then 'd' with out_en=1, no eow. fifo_count returns to 0.
- Push "AnDrE\n" -> out_char a,n,d,r,e with out_en=1 each, then out_eow=1. drop_cnt=0.
- MAX_LEN=4, push "abcdefg " -> out_en for a..d only, then one out_eow with out_too_long=1. drop_cnt=0.
- hold=1, push 10 bytes with in_valid held high -> in_ready drops after 8 accepts and fifo_count=8. Release hold -> 8 outputs drain, in_ready=1 one edge after the first pop.
- Push "a1#b  c" -> drop_cnt=2, out chars a,b then eow, then c. Double space yields one eow only.
- Assert reset after "ab" pushed and 'a' emitted -> all outputs 0 next cycle, fifo_count=0. Subsequent " x" produces no eow, then 'x' with out_en=1.
